// File: rtl/i2c_target_responder.sv
// i2c_target_responder: oversampled I2C target with an auto-incrementing register file and a write strobe.
module i2c_target_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h48,
    parameter int REG_AW = 4
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              wr_strobe,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK, S_WDATA, S_WDATA_ACK, S_RDATA, S_MACK, S_WAIT
    } state_t;

    state_t              state;
    logic [2:0]          scl_s, sda_s;
    logic [3:0]          cnt;
    logic [7:0]          sh;
    logic [REG_AW-1:0]   ptr;
    logic                rw;
    logic [7:0]          regs [2**REG_AW];

    logic scl, sda, scl_rise, scl_fall, start, stop;
    logic [7:0] rx_byte;

    assign scl      = scl_s[1];
    assign sda      = sda_s[1];
    assign scl_rise = scl_s[1] & ~scl_s[2];
    assign scl_fall = ~scl_s[1] & scl_s[2];
    assign start    = scl & sda_s[2] & ~sda_s[1];
    assign stop     = scl & ~sda_s[2] & sda_s[1];
    assign rx_byte  = {sh[6:0], sda};
    assign busy     = !(state inside {S_IDLE, S_WAIT});
    assign dbg_data = regs[dbg_addr];

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            scl_s     <= 3'b111;
            sda_s     <= 3'b111;
            state     <= S_IDLE;
            cnt       <= '0;
            sh        <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int i = 0; i < 2**REG_AW; i++) regs[i] <= 8'h00;
        end else begin
            scl_s     <= {scl_s[1:0], scl_in};
            sda_s     <= {sda_s[1:0], sda_in};
            wr_strobe <= 1'b0;
            if (start) begin
                state  <= S_ADDR;
                cnt    <= '0;
                sda_oe <= 1'b0;
            end else if (stop) begin
                state  <= S_IDLE;
                sda_oe <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    S_ADDR, S_REG, S_WDATA: begin
                        sh  <= rx_byte;
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt <= '0;
                            if (state == S_ADDR) begin
                                state <= (rx_byte[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_WAIT;
                                rw    <= rx_byte[0];
                            end else if (state == S_REG) begin
                                ptr   <= rx_byte[REG_AW-1:0];
                                state <= S_REG_ACK;
                            end else begin
                                regs[ptr] <= rx_byte;
                                wr_strobe <= 1'b1;
                                wr_addr   <= ptr;
                                wr_data   <= rx_byte;
                                ptr       <= ptr + REG_AW'(1);
                                state     <= S_WDATA_ACK;
                            end
                        end
                    end
                    S_MACK: if (sda) state <= S_WAIT;
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    // first fall after the byte asserts ACK, the next one ends the ACK bit
                    S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
                        if (!sda_oe) sda_oe <= 1'b1;
                        else begin
                            sda_oe <= 1'b0;
                            state  <= (state != S_ADDR_ACK) ? S_WDATA : rw ? S_RDATA : S_REG;
                            if (state == S_ADDR_ACK && rw) begin
                                sda_oe <= ~regs[ptr][7];
                                sh     <= {regs[ptr][6:0], 1'b0};
                                cnt    <= 4'd1;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (cnt == 4'd8) begin
                            sda_oe <= 1'b0;
                            ptr    <= ptr + REG_AW'(1);
                            cnt    <= '0;
                            state  <= S_MACK;
                        end else begin
                            sda_oe <= ~sh[7];
                            sh     <= {sh[6:0], 1'b0};
                            cnt    <= cnt + 4'd1;
                        end
                    end
                    S_MACK: begin
                        sda_oe <= ~regs[ptr][7];
                        sh     <= {regs[ptr][6:0], 1'b0};
                        cnt    <= 4'd1;
                        state  <= S_RDATA;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_responder.sv
// tb_i2c_target_responder: bit-banged I2C master with a register-file/strobe reference model.
module tb_i2c_target_responder;
    logic       sys_clk = 1'b0, reset = 1'b1, scl = 1'b1, sda_m = 1'b1;
    logic [3:0] dbg_addr = 4'd0;
    logic       sda_oe, wr_strobe, busy, sda_bus;
    logic [3:0] wr_addr;
    logic [7:0] wr_data, dbg_data;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_responder #(.DEV_ADDR(7'h48), .REG_AW(4)) dut (
        .sys_clk(sys_clk), .reset(reset), .scl_in(scl), .sda_in(sda_bus),
        .sda_oe(sda_oe), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 sys_clk = ~sys_clk;

    int          tests = 0, fails = 0;
    logic [7:0]  exp_regs [16];
    int          exp_ptr = 0;
    logic [11:0] sq[$], eq[$];
    logic        oe_seen = 1'b0;
    logic [7:0]  wbuf [8];

    always @(negedge sys_clk) begin
        if (wr_strobe) sq.push_back({wr_addr, wr_data});
        if (sda_oe) oe_seen = 1'b1;
    end

    initial begin
        #900_000;
        $display("FAIL timeout reached before summary");
        $fatal(1, "timeout");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // one SCL period starting and ending with SCL low; s is the bus level mid-high
    task automatic clk_bit(input logic b, output logic s);
        wait_cyc(5); sda_m = b; wait_cyc(5); scl = 1'b1;
        wait_cyc(5); s = sda_bus; wait_cyc(5); scl = 1'b0;
    endtask

    task automatic bus_start;
        wait_cyc(5); sda_m = 1'b1; wait_cyc(5); scl = 1'b1;
        wait_cyc(10); sda_m = 1'b0; wait_cyc(10); scl = 1'b0;
    endtask

    task automatic bus_stop;
        wait_cyc(5); sda_m = 1'b0; wait_cyc(5); scl = 1'b1;
        wait_cyc(10); sda_m = 1'b1; wait_cyc(10);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(~mack, s);
    endtask

    task automatic write_txn(input logic [7:0] p, input int n, output int nacks);
        logic a;
        nacks = 0;
        bus_start;
        send_byte(8'h90, a); nacks += int'(!a);
        send_byte(p, a);     nacks += int'(!a);
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], a);
            nacks += int'(!a);
        end
        bus_stop;
    endtask

    task automatic model_write(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            exp_regs[(p + i) % 16] = wbuf[i];
            eq.push_back({4'((p + i) % 16), wbuf[i]});
        end
        exp_ptr = (p + n) % 16;
    endtask

    task automatic test_reset;
        reset = 1'b1; wait_cyc(3); reset = 1'b0; wait_cyc(2);
        foreach (exp_regs[i]) exp_regs[i] = 8'h00;
        exp_ptr = 0;
        tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (wr_strobe !== 1'b0) begin fails++; $display("FAIL reset_wr_strobe got %b want 0", wr_strobe); end
        tests++; if ({wr_addr, wr_data} !== 12'h000) begin fails++; $display("FAIL reset_wr_bus got %h want 000", {wr_addr, wr_data}); end
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i); wait_cyc(1);
            tests++; if (dbg_data !== exp_regs[i]) begin fails++; $display("FAIL reset_reg%0d got %h want %h", i, dbg_data, exp_regs[i]); end
        end
    endtask

    task automatic test_write_basic;
        int nk;
        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
        write_txn(8'h03, 2, nk);
        model_write(3, 2);
        tests++; if (nk != 0) begin fails++; $display("FAIL basic_acks got %0d nacks want 0", nk); end
        tests++;
        if (sq.size() != eq.size()) begin fails++; $display("FAIL basic_strobe_count got %0d want %0d", sq.size(), eq.size()); end
        else foreach (eq[i]) begin
            tests++; if (sq[i] !== eq[i]) begin fails++; $display("FAIL basic_strobe%0d got %h want %h", i, sq[i], eq[i]); end
        end
        sq.delete(); eq.delete();
        dbg_addr = 4'd4; wait_cyc(1);
        tests++; if (dbg_data !== 8'h5A) begin fails++; $display("FAIL basic_dbg4 got %h want 5a", dbg_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after_stop got %b want 0", busy); end
    endtask

    task automatic test_mismatch;
        logic a;
        int nk;
        bus_start;
        oe_seen = 1'b0;
        send_byte(8'h92, a);
        tests++; if (a !== 1'b0) begin fails++; $display("FAIL mismatch_ack got %b want 0", a); end
        tests++; if (oe_seen !== 1'b0) begin fails++; $display("FAIL mismatch_sda_oe got %b want 0", oe_seen); end
        wait_cyc(2);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mismatch_busy got %b want 0", busy); end
        send_byte(8'($urandom), a);
        tests++; if (a !== 1'b0) begin fails++; $display("FAIL mismatch_wait_ack got %b want 0", a); end
        bus_stop;
        tests++; if (sq.size() != 0) begin fails++; $display("FAIL mismatch_strobes got %0d want 0", sq.size()); end
        sq.delete();
        wbuf[0] = 8'($urandom);
        write_txn(8'h07, 1, nk);
        model_write(7, 1);
        tests++; if (nk != 0) begin fails++; $display("FAIL mismatch_followup_acks got %0d nacks want 0", nk); end
        tests++; if (sq.size() != 1 || sq[0] !== eq[0]) begin fails++; $display("FAIL mismatch_followup_strobe got %0d entries want %h", sq.size(), eq[0]); end
        sq.delete(); eq.delete();
    endtask

    task automatic test_wrap;
        int nk;
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        write_txn({4'($urandom), 4'hF}, 2, nk);
        model_write(15, 2);
        tests++; if (nk != 0) begin fails++; $display("FAIL wrap_acks got %0d nacks want 0", nk); end
        tests++;
        if (sq.size() != 2) begin fails++; $display("FAIL wrap_strobe_count got %0d want 2", sq.size()); end
        else foreach (eq[i]) begin
            tests++; if (sq[i] !== eq[i]) begin fails++; $display("FAIL wrap_strobe%0d got %h want %h", i, sq[i], eq[i]); end
        end
        sq.delete(); eq.delete();
        dbg_addr = 4'd15; wait_cyc(1);
        tests++; if (dbg_data !== 8'h11) begin fails++; $display("FAIL wrap_reg15 got %h want 11", dbg_data); end
        dbg_addr = 4'd0; wait_cyc(1);
        tests++; if (dbg_data !== 8'h22) begin fails++; $display("FAIL wrap_reg0 got %h want 22", dbg_data); end
    endtask

    task automatic test_read;
        int nk;
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        wbuf[0] = 8'hC3; wbuf[1] = 8'h3C;
        write_txn(8'h02, 2, nk);
        model_write(2, 2);
        sq.delete(); eq.delete();
        bus_start;
        send_byte(8'h90, a0);
        send_byte(8'h02, a1);
        bus_start;
        send_byte(8'h91, a2);
        read_byte(1'b1, d0);
        read_byte(1'b0, d1);
        exp_ptr = 4;
        wait_cyc(4);
        tests++; if ({a0, a1, a2} !== 3'b111) begin fails++; $display("FAIL read_acks got %b want 111", {a0, a1, a2}); end
        tests++; if (d0 !== exp_regs[2]) begin fails++; $display("FAIL read_byte0 got %h want %h", d0, exp_regs[2]); end
        tests++; if (d1 !== exp_regs[3]) begin fails++; $display("FAIL read_byte1 got %h want %h", d1, exp_regs[3]); end
        tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL read_release got %b want 0", sda_oe); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL read_wait_busy got %b want 0", busy); end
        bus_stop;
    endtask

    task automatic test_reset_mid;
        logic s;
        bus_start;
        for (int i = 7; i >= 0; i--) clk_bit(1'(8'h90 >> i), s);
        wait_cyc(5);
        tests++; if (sda_oe !== 1'b1) begin fails++; $display("FAIL rstmid_ack_driven got %b want 1", sda_oe); end
        reset = 1'b1; wait_cyc(1);
        tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL rstmid_sda_oe got %b want 0", sda_oe); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy); end
        reset = 1'b0;
        foreach (exp_regs[i]) exp_regs[i] = 8'h00;
        exp_ptr = 0;
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i); wait_cyc(1);
            tests++; if (dbg_data !== exp_regs[i]) begin fails++; $display("FAIL rstmid_reg%0d got %h want %h", i, dbg_data, exp_regs[i]); end
        end
        sda_m = 1'b1; wait_cyc(5); scl = 1'b1; wait_cyc(10);
    endtask

    task automatic test_stop_mid;
        int nk;
        logic a, s;
        logic [7:0] d;
        wbuf[0] = 8'($urandom);
        write_txn(8'h05, 1, nk);
        model_write(5, 1);
        sq.delete(); eq.delete();
        bus_start;
        send_byte(8'h90, a);
        send_byte(8'h05, a);
        for (int i = 0; i < 4; i++) clk_bit(1'($urandom), s);
        bus_stop;
        exp_ptr = 5;
        dbg_addr = 4'd5; wait_cyc(1);
        tests++; if (sq.size() != 0) begin fails++; $display("FAIL stopmid_strobes got %0d want 0", sq.size()); end
        tests++; if (dbg_data !== exp_regs[5]) begin fails++; $display("FAIL stopmid_reg5 got %h want %h", dbg_data, exp_regs[5]); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stopmid_busy got %b want 0", busy); end
        bus_start;
        send_byte(8'h91, a);
        read_byte(1'b0, d);
        tests++; if (a !== 1'b1 || d !== exp_regs[exp_ptr]) begin fails++; $display("FAIL stopmid_retained_read got ack %b data %h want ack 1 data %h", a, d, exp_regs[exp_ptr]); end
        exp_ptr = (exp_ptr + 1) % 16;
        bus_stop;
        sq.delete();
    endtask

    task automatic test_back_to_back;
        int nk, p, n, m;
        logic a0, a1, a2;
        logic [7:0] d;
        for (int t = 0; t < 6; t++) begin
            p = int'($urandom_range(0, 255));
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            write_txn(8'(p), n, nk);
            model_write(p % 16, n);
            tests++; if (nk != 0) begin fails++; $display("FAIL b2b%0d_acks got %0d nacks want 0", t, nk); end
            tests++;
            if (sq.size() != eq.size()) begin fails++; $display("FAIL b2b%0d_strobe_count got %0d want %0d", t, sq.size(), eq.size()); end
            else foreach (eq[i]) begin
                tests++; if (sq[i] !== eq[i]) begin fails++; $display("FAIL b2b%0d_strobe%0d got %h want %h", t, i, sq[i], eq[i]); end
            end
            sq.delete(); eq.delete();
            p = int'($urandom_range(0, 15));
            m = int'($urandom_range(1, 4));
            bus_start;
            send_byte(8'h90, a0);
            send_byte(8'(p), a1);
            bus_start;
            send_byte(8'h91, a2);
            tests++; if ({a0, a1, a2} !== 3'b111) begin fails++; $display("FAIL b2b%0d_read_acks got %b want 111", t, {a0, a1, a2}); end
            for (int i = 0; i < m; i++) begin
                read_byte(i != m - 1, d);
                tests++; if (d !== exp_regs[(p + i) % 16]) begin fails++; $display("FAIL b2b%0d_read%0d got %h want %h", t, i, d, exp_regs[(p + i) % 16]); end
            end
            exp_ptr = (p + m) % 16;
            bus_stop;
        end
    endtask

    initial begin
        test_reset;
        test_write_basic;
        test_mismatch;
        test_wrap;
        test_read;
        test_reset_mid;
        test_stop_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
